iterative_normalizer: RTL and testbench

//  Multi-cycle inverse of the left barrel shifter: given a word, finds the left shift that

---
 rtl/iterative_normalizer.sv | 80 ++++++++
 tb/tb_iterative_normalizer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/iterative_normalizer.sv
// Leading-zero normalizer: one binary-search stage (16,8,4,2,1) per cycle, done LOG2W+1 cycles after start.
// No backpressure: start is taken only while ready=1 (IDLE or DONE) and ignored during RUN.
module iterative_normalizer #(
  parameter int WIDTH = 32,
  parameter int LOG2W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [LOG2W-1:0] shamt,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] w, w_nxt;
  logic [LOG2W-1:0] cnt, cnt_nxt, step;
  logic [LOG2W:0]   k;
  logic             last;

  // One search stage: if the top k bits are empty, shift them out and set the matching shamt bit.
  always_comb begin
    k       = (LOG2W+1)'(WIDTH >> (int'(step) + 1));
    last    = (step == LOG2W'(LOG2W-1));
    w_nxt   = w;
    cnt_nxt = cnt;
    if ((w >> (WIDTH - int'(k))) == '0) begin
      w_nxt   = w << k;
      cnt_nxt = cnt | (LOG2W'(1) << (LOG2W'(LOG2W-1) - step));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = (state != RUN);
    done      = (state == DONE);
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final w is all-zero exactly when the operand was, so zero needs no separate copy of din.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w     <= '0;
      cnt   <= '0;
      step  <= '0;
      dout  <= '0;
      shamt <= '0;
      zero  <= 1'b0;
    end else if (start && state != RUN) begin
      w    <= din;
      cnt  <= '0;
      step <= '0;
    end else if (state == RUN) begin
      w    <= w_nxt;
      cnt  <= cnt_nxt;
      step <= step + LOG2W'(1);
      if (last) begin
        dout  <= w_nxt;
        shamt <= cnt_nxt;
        zero  <= (w_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_iterative_normalizer.sv
// Directed and random checks of iterative_normalizer against a bit-scan leading-zero reference.
module tb_iterative_normalizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] din   = '0;
  logic        ready, done, zero;
  logic [31:0] dout;
  logic [4:0]  shamt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_dout = '0;

  iterative_normalizer #(.WIDTH(32), .LOG2W(5)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .din   (din),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .shamt (shamt),
    .zero  (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lzc(input logic [31:0] d);
    for (int i = 31; i >= 0; i--)
      if (d[i]) return 31 - i;
    return 31;
  endfunction

  // Called at a negedge with ready expected high; returns at the negedge where done is seen.
  task automatic do_op(input string tag, input logic [31:0] d, input bit spam);
    int          lat;
    int          lz;
    logic [31:0] exp_dout;
    lz       = ref_lzc(d);
    exp_dout = (d == 0) ? 32'h0 : (d << lz);
    chk({tag, ".ready"}, 64'(ready), 64'(1));
    din   = d;
    start = 1'b1;
    lat   = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (done || lat > 20) break;
      if (lat == 3) chk({tag, ".hold"}, 64'(dout), 64'(last_dout));
      start = spam;
      din   = spam ? $urandom : d;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(6));
    chk({tag, ".dout"}, 64'(dout), 64'(exp_dout));
    chk({tag, ".shamt"}, 64'(shamt), 64'(lz));
    chk({tag, ".zero"}, 64'(zero), 64'(d == 0));
    last_dout = exp_dout;
  endtask

  task automatic idle_after(input string tag);
    @(negedge clock);
    chk({tag, ".done_pulse"}, 64'(done), 64'(0));
    chk({tag, ".ready_idle"}, 64'(ready), 64'(1));
  endtask

  initial begin
    logic [31:0] d;
    #1;
    chk("rst.ready", 64'(ready), 64'(1));
    chk("rst.done",  64'(done),  64'(0));
    chk("rst.dout",  64'(dout),  64'(0));
    chk("rst.shamt", 64'(shamt), 64'(0));
    chk("rst.zero",  64'(zero),  64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    do_op("lsb", 32'h0000_0001, 1'b0);
    chk("lsb.exact", 64'(dout), 64'h8000_0000);
    chk("lsb.sh31", 64'(shamt), 64'd31);
    idle_after("lsb");
    do_op("msb", 32'h8000_0000, 1'b0);
    idle_after("msb");
    do_op("mid", 32'h0001_2345, 1'b0);
    chk("mid.exact", 64'(dout), 64'h91A2_8000);
    chk("mid.sh15", 64'(shamt), 64'd15);
    idle_after("mid");
    do_op("zero", 32'h0, 1'b0);
    chk("zero.sh31", 64'(shamt), 64'd31);
    idle_after("zero");

    do_op("busy", 32'h0001_2345, 1'b1);
    do_op("b2b", 32'h0000_00F0, 1'b0);
    chk("b2b.exact", 64'(dout), 64'hF000_0000);
    chk("b2b.sh24", 64'(shamt), 64'd24);
    idle_after("b2b");

    din   = 32'h0000_0003;
    start = 1'b1;
    @(posedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst.ready", 64'(ready), 64'(1));
    chk("mid_rst.done",  64'(done),  64'(0));
    chk("mid_rst.dout",  64'(dout),  64'(0));
    chk("mid_rst.shamt", 64'(shamt), 64'(0));
    chk("mid_rst.zero",  64'(zero),  64'(0));
    last_dout = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_op("post_rst", 32'h0000_0003, 1'b0);
    chk("post_rst.exact", 64'(dout), 64'hC000_0000);
    idle_after("post_rst");

    for (int i = 0; i < 10000; i++) begin
      case (i % 4)
        0:       d = 32'h1 << $urandom_range(31);
        1:       d = $urandom >> $urandom_range(31);
        default: d = $urandom;
      endcase
      if (i % 997 == 0) d = 32'h0;
      do_op("rnd", d, 1'b0);
      if (d != 0) begin
        chk("rnd.msb", 64'(dout[31]), 64'(1));
        chk("rnd.inverse", 64'(dout >> shamt), 64'(d));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
